// File: rtl/div_share_arb_pkg.sv
// Shared types and elaboration helpers for the divider-sharing arbiter.
package div_share_arb_pkg;

  // FSM encoding used by div_share_arb.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // Width of a requester index; never narrower than one bit.
  function automatic int id_width(input int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

  // The watchdog must outlast the slowest legal divider run.
  function automatic bit timeout_ok(input int width, input int fbits, input int timeout);
    return timeout > (width - 1 + fbits + 4);
  endfunction

endpackage

// File: rtl/div_share_arb_rr_arb.sv
// Round-robin picker: first set request at or above the pointer, with wrap.
module div_share_arb_rr_arb #(
  parameter int NREQ = 4,
  parameter int ID_W = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [ID_W-1:0] i_ptr,
  output logic [NREQ-1:0] o_gnt,
  output logic [ID_W-1:0] o_id,
  output logic            o_any
);

  int k;

  // Scan NREQ positions starting at the pointer; the first hit wins.
  always_comb begin
    o_gnt = '0;
    o_id  = '0;
    o_any = 1'b0;
    k     = 0;
    for (int i = 0; i < NREQ; i++) begin
      k = (int'(i_ptr) + i) % NREQ;
      if (!o_any && i_req[k]) begin
        o_any    = 1'b1;
        o_gnt[k] = 1'b1;
        o_id     = ID_W'(k);
      end
    end
  end

endmodule

// File: rtl/div_share_arb.sv
// Shares one sequential divider among NREQ requesters, round-robin, one
// division in flight. Optional macro DIV_ARB_DBZ_EN answers b==0 requests
// locally with a saturated quotient instead of starting the divider.
//
// state | meaning
// IDLE  | arbitrate; accept one request and latch its operands
// ISSUE | pulse div_start, clear watchdog
// WAIT  | wait for div_done or watchdog expiry
// RESP  | pulse rsp_valid to the owner, advance round-robin pointer
module div_share_arb
  import div_share_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 16,
  parameter int FBITS   = 12,
  parameter int TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  i_rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]      rsp_q,
  output logic                  rsp_err,
  output logic                  rsp_dbz,
  output logic                  div_start,
  output logic [WIDTH-1:0]      div_a,
  output logic [WIDTH-1:0]      div_b,
  input  logic                  div_done,
  input  logic [WIDTH-1:0]      div_val
);

  localparam int ID_W = id_width(NREQ);
  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT - 1);
  localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  if (!timeout_ok(WIDTH, FBITS, TIMEOUT)) begin : g_bad_timeout
    $error("div_share_arb: TIMEOUT too small for WIDTH/FBITS");
  end

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [ID_W-1:0]  id;
  } req_t;

  state_t           r_state, w_next;
  req_t             r_req;
  logic [ID_W-1:0]  r_rr_ptr;
  logic [WD_W-1:0]  r_wd_cnt;
  logic             r_div_start;
  logic [NREQ-1:0]  r_rsp_valid;
  logic [WIDTH-1:0] r_rsp_q;
  logic             r_rsp_err;
  logic             r_rsp_dbz;

  logic [NREQ-1:0]  w_gnt;
  logic [ID_W-1:0]  w_gnt_id;
  logic [ID_W-1:0]  w_rsp_id;
  logic             w_any;
  logic [WIDTH-1:0] w_sel_a;
  logic [WIDTH-1:0] w_sel_b;
  logic             w_dbz_hit;

  div_share_arb_rr_arb #(.NREQ(NREQ), .ID_W(ID_W)) u_rr_arb (
    .i_req (req_valid),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_gnt),
    .o_id  (w_gnt_id),
    .o_any (w_any)
  );

  assign w_sel_a  = req_a[int'(w_gnt_id)*WIDTH +: WIDTH];
  assign w_sel_b  = req_b[int'(w_gnt_id)*WIDTH +: WIDTH];
  assign w_rsp_id = (r_state == ST_IDLE) ? w_gnt_id : r_req.id;

`ifdef DIV_ARB_DBZ_EN
  assign w_dbz_hit = (w_sel_b == '0);
`else
  assign w_dbz_hit = 1'b0;
`endif

  assign div_start = r_div_start;
  assign div_a     = r_req.a;
  assign div_b     = r_req.b;
  assign rsp_valid = r_rsp_valid;
  assign rsp_q     = r_rsp_q;
  assign rsp_err   = r_rsp_err;
  assign rsp_dbz   = r_rsp_dbz;

  // State register.
  always_ff @(posedge clk) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  // Next state and the combinational accept strobe.
  always_comb begin
    w_next    = r_state;
    req_ready = '0;
    case (r_state)
      ST_IDLE: begin
        req_ready = w_gnt;
        if (w_any) w_next = w_dbz_hit ? ST_RESP : ST_ISSUE;
      end
      ST_ISSUE: w_next = ST_WAIT;
      ST_WAIT:  if (div_done || (r_wd_cnt == WD_LAST)) w_next = ST_RESP;
      ST_RESP:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Operand latch, divider start, watchdog, response registers, rr pointer.
  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      r_req       <= '0;
      r_rr_ptr    <= '0;
      r_wd_cnt    <= '0;
      r_div_start <= 1'b0;
      r_rsp_valid <= '0;
      r_rsp_q     <= '0;
      r_rsp_err   <= 1'b0;
      r_rsp_dbz   <= 1'b0;
    end else begin
      r_div_start <= 1'b0;
      r_rsp_valid <= '0;
      if (w_next == ST_RESP) r_rsp_valid[w_rsp_id] <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_req <= '{a: w_sel_a, b: w_sel_b, id: w_gnt_id};
            if (w_dbz_hit) begin
              r_rsp_q   <= w_sel_a[WIDTH-1] ? SAT_NEG : SAT_POS;
              r_rsp_err <= 1'b0;
              r_rsp_dbz <= 1'b1;
            end else begin
              r_div_start <= 1'b1;
            end
          end
        end
        ST_ISSUE: r_wd_cnt <= '0;
        ST_WAIT: begin
          // A completion in the expiry cycle still delivers a normal result.
          if (div_done) begin
            r_rsp_q   <= div_val;
            r_rsp_err <= 1'b0;
            r_rsp_dbz <= 1'b0;
          end else if (r_wd_cnt == WD_LAST) begin
            r_rsp_q   <= '0;
            r_rsp_err <= 1'b1;
            r_rsp_dbz <= 1'b0;
          end else begin
            r_wd_cnt <= r_wd_cnt + 1'b1;
          end
        end
        ST_RESP: r_rr_ptr <= (r_req.id == ID_W'(NREQ - 1)) ? '0 : r_req.id + 1'b1;
        default: ;
      endcase
    end
  end

endmodule
